// File: rtl/switch_chk_pkg.sv
// switch_chk_pkg: shared types and default constants for the switch_checker block.
package switch_chk_pkg;

   // FSM encoding is exposed directly on state_o, so the values are fixed.
   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      FAULT  = 2'd3
   } state_e;

   // Width of the free-running stimulus edge counter.
   localparam int EDGE_CNT_W = 16;

   // Default parameter values for switch_checker.
   localparam int DEF_SYNC_STAGES  = 2;
   localparam int DEF_SETTLE_CYC   = 2;
   localparam int DEF_CNT_W        = 10;
   localparam int DEF_MAX_HALF_PER = 1023;

endpackage

// File: rtl/switch_checker_sync_bit.sv
// sync_bit: STAGES-deep flop chain bringing one asynchronous bit into the clk domain.
// All flops clear to 0 on reset, so a low input never produces a spurious edge.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the raw input through the synchronizer chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/switch_checker.sv
// switch_checker: receive-side checker for the switch-level inverter stage.
// Synchronizes stimulus and response, waits a settle window after every stimulus
// edge, then checks that the response is the inverted stimulus. Counts edges and
// keeps sticky fault flags.
// Build option: define SWITCH_CHK_PERIOD_EN to implement half-period measurement
// and stuck detection; otherwise half_per_o and stuck_o are tied to 0.
module switch_checker
   import switch_chk_pkg::*;
#(
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int MAX_HALF_PER = DEF_MAX_HALF_PER
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable_i,
   input  logic                  clr_i,
   input  logic                  stim_i,
   input  logic                  resp_i,
   output logic                  err_pulse_o,
   output logic                  mismatch_o,
   output logic                  stuck_o,
   output logic [EDGE_CNT_W-1:0] edge_cnt_o,
   output logic [CNT_W-1:0]      half_per_o,
   output logic [STATE_W-1:0]    state_o
);

   // Settle counter only has to hold SETTLE_CYC-1.
   localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);

   logic stim_s;
   logic resp_s;
   logic stim_d_q;
   logic stim_edge;
   logic resp_bad;

   state_e                state_q, state_d;
   logic [SETTLE_W-1:0]   settle_q, settle_d;
   logic                  err_q, err_d;
   logic                  mismatch_q, mismatch_d;
   logic [EDGE_CNT_W-1:0] edge_cnt_q;

   // Both inputs see the same synchronizer depth so their relative timing is kept.
   sync_bit #(.STAGES(SYNC_STAGES)) u_sync_stim (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (stim_i),
      .q_o   (stim_s)
   );

   sync_bit #(.STAGES(SYNC_STAGES)) u_sync_resp (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (resp_i),
      .q_o   (resp_s)
   );

   // Delayed copy of the synchronized stimulus for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stim_d_q <= 1'b0;
      end else begin
         stim_d_q <= stim_s;
      end
   end

   assign stim_edge = stim_s ^ stim_d_q;
   // A correct inverter never shows the same level on response and stimulus.
   assign resp_bad  = (resp_s == stim_s);

   // FSM and sticky mismatch flag: registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         settle_q   <= '0;
         err_q      <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         err_q      <= err_d;
         mismatch_q <= mismatch_d;
      end
   end

   // FSM next state. The last settle cycle (counter at 0) is also the first
   // compare cycle, so the comparison starts SETTLE_CYC cycles after the edge.
   always_comb begin
      state_d    = state_q;
      settle_d   = settle_q;
      err_d      = 1'b0;
      mismatch_d = mismatch_q;
      if (clr_i) begin
         state_d    = IDLE;
         settle_d   = '0;
         mismatch_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (enable_i && stim_edge) begin
                  state_d  = SETTLE;
                  settle_d = SETTLE_LOAD;
               end
            end
            SETTLE: begin
               if (!enable_i) begin
                  state_d = IDLE;
               end else if (stim_edge) begin
                  settle_d = SETTLE_LOAD;
               end else if (settle_q != '0) begin
                  settle_d = settle_q - SETTLE_W'(1);
               end else if (resp_bad) begin
                  state_d    = FAULT;
                  err_d      = 1'b1;
                  mismatch_d = 1'b1;
               end else begin
                  state_d = CHECK;
               end
            end
            CHECK: begin
               // An edge wins over the compare: the response is allowed to move.
               if (!enable_i) begin
                  state_d = IDLE;
               end else if (stim_edge) begin
                  state_d  = SETTLE;
                  settle_d = SETTLE_LOAD;
               end else if (resp_bad) begin
                  state_d    = FAULT;
                  err_d      = 1'b1;
                  mismatch_d = 1'b1;
               end
            end
            FAULT: begin
               state_d = FAULT;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Edge counter: counts every enabled edge in any state, wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt_q <= '0;
      end else if (clr_i) begin
         edge_cnt_q <= '0;
      end else if (enable_i && stim_edge) begin
         edge_cnt_q <= edge_cnt_q + EDGE_CNT_W'(1);
      end
   end

`ifdef SWITCH_CHK_PERIOD_EN
   localparam logic [CNT_W-1:0] CNT_SAT   = '1;
   localparam logic [CNT_W-1:0] STUCK_LIM = CNT_W'(MAX_HALF_PER);

   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0] half_per_q, half_per_d;
   logic             stuck_q, stuck_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_SAT) ? v : v + CNT_W'(1);
   endfunction

   // Run length since the last edge, latched half-period and stuck flag.
   always_comb begin
      run_cnt_d  = run_cnt_q;
      half_per_d = half_per_q;
      stuck_d    = stuck_q;
      if (clr_i) begin
         run_cnt_d  = '0;
         half_per_d = '0;
         stuck_d    = 1'b0;
      end else if (enable_i) begin
         if (run_cnt_q >= STUCK_LIM) begin
            stuck_d = 1'b1;
         end
         if (stim_edge) begin
            half_per_d = sat_inc(run_cnt_q);
            run_cnt_d  = '0;
         end else begin
            run_cnt_d = sat_inc(run_cnt_q);
         end
      end
   end

   // Period measurement registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt_q  <= '0;
         half_per_q <= '0;
         stuck_q    <= 1'b0;
      end else begin
         run_cnt_q  <= run_cnt_d;
         half_per_q <= half_per_d;
         stuck_q    <= stuck_d;
      end
   end

   assign half_per_o = half_per_q;
   assign stuck_o    = stuck_q;
`else
   logic unused_max_half_per;

   assign half_per_o          = '0;
   assign stuck_o             = 1'b0;
   assign unused_max_half_per = ^CNT_W'(MAX_HALF_PER);
`endif

   assign err_pulse_o = err_q;
   assign mismatch_o  = mismatch_q;
   assign edge_cnt_o  = edge_cnt_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_switch_checker.sv
// tb_switch_checker: table-driven and randomized self-checking bench for switch_checker.
// The reference model tracks "cycles since the last stimulus edge" rather than FSM states.
module tb_switch_checker;

   localparam int SYNC = 2;
   localparam int SET  = 2;
   localparam int CW   = 10;
   localparam int MAXH = 1023;
   localparam int SATV = (1 << CW) - 1;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic          clr;
   logic          stim;
   logic          resp;
   logic          err_pulse;
   logic          mismatch;
   logic          stuck;
   logic [15:0]   edge_cnt;
   logic [CW-1:0] half_per;
   logic [1:0]    state;

   switch_checker dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable_i    (en),
      .clr_i       (clr),
      .stim_i      (stim),
      .resp_i      (resp),
      .err_pulse_o (err_pulse),
      .mismatch_o  (mismatch),
      .stuck_o     (stuck),
      .edge_cnt_o  (edge_cnt),
      .half_per_o  (half_per),
      .state_o     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // ---------------- reference model ----------------
   int hs[SYNC+2];
   int hr[SYNC+2];
   int m_edges, m_run, m_half, m_age;
   bit m_stuck, m_mis, m_err, m_active, m_fault;

   task automatic model_reset();
      for (int i = 0; i < SYNC + 2; i++) begin
         hs[i] = 0;
         hr[i] = 0;
      end
      m_edges = 0; m_run = 0; m_half = 0; m_age = 0;
      m_stuck = 0; m_mis = 0; m_err = 0; m_active = 0; m_fault = 0;
   endtask

   // One rising edge: inputs applied now reach the checker SYNC cycles later.
   task automatic model_step();
      int s, d, r, run_old;
      bit e;
      for (int i = SYNC + 1; i > 0; i--) begin
         hs[i] = hs[i-1];
         hr[i] = hr[i-1];
      end
      hs[0] = int'(stim);
      hr[0] = int'(resp);
      s = hs[SYNC];
      d = hs[SYNC+1];
      r = hr[SYNC];
      e = (s != d);
      if (clr) begin
         m_edges = 0; m_run = 0; m_half = 0; m_age = 0;
         m_stuck = 0; m_mis = 0; m_err = 0; m_active = 0; m_fault = 0;
      end else begin
         m_err = 0;
         if (en && e) m_edges = (m_edges + 1) % 65536;
         if (en) begin
            run_old = m_run;
            if (run_old >= MAXH) m_stuck = 1;
            if (e) begin
               m_half = (run_old + 1 > SATV) ? SATV : run_old + 1;
               m_run  = 0;
            end else begin
               m_run = (run_old + 1 > SATV) ? SATV : run_old + 1;
            end
         end
         if (!m_fault) begin
            if (!en) begin
               m_active = 0;
            end else if (e) begin
               m_active = 1;
               m_age    = 0;
            end else if (m_active) begin
               if (m_age < SET) m_age++;
               if (m_age >= SET && r == s) begin
                  m_fault = 1;
                  m_mis   = 1;
                  m_err   = 1;
               end
            end
         end
      end
   endtask

   function automatic int exp_state();
      if (m_fault) return 3;
      if (!m_active) return 0;
      return (m_age < SET) ? 1 : 2;
   endfunction

   function automatic int exp_half();
`ifdef SWITCH_CHK_PERIOD_EN
      return m_half;
`else
      return 0;
`endif
   endfunction

   function automatic int exp_stuck();
`ifdef SWITCH_CHK_PERIOD_EN
      return int'(m_stuck);
`else
      return 0;
`endif
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] act, input int exp_v);
      n_vec++;
      if (act !== 32'(exp_v)) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   task automatic check_all();
      chk("state",     32'(state),     exp_state());
      chk("err_pulse", 32'(err_pulse), int'(m_err));
      chk("mismatch",  32'(mismatch),  int'(m_mis));
      chk("edge_cnt",  32'(edge_cnt),  m_edges);
      chk("half_per",  32'(half_per),  exp_half());
      chk("stuck",     32'(stuck),     exp_stuck());
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_state"},     32'(state),     0);
      chk({tag, "_err"},       32'(err_pulse), 0);
      chk({tag, "_mismatch"},  32'(mismatch),  0);
      chk({tag, "_edge_cnt"},  32'(edge_cnt),  0);
      chk({tag, "_half_per"},  32'(half_per),  0);
      chk({tag, "_stuck"},     32'(stuck),     0);
   endtask

   typedef struct {
      bit en;
      bit clr;
      bit s;
      bit r;
      int st;
      bit err;
      bit mis;
      int edges;
   } vec_t;

   function automatic vec_t mk(bit e_, bit c_, bit s_, bit r_, int st_, bit er_, bit mi_, int ed_);
      vec_t v;
      v.en = e_; v.clr = c_; v.s = s_; v.r = r_;
      v.st = st_; v.err = er_; v.mis = mi_; v.edges = ed_;
      return v;
   endfunction

   vec_t tbl[16];

   initial begin
      int saved_edges;
      int hp;
      int dly[4];

      // Buffer stage (resp = stim), then clear, then clear racing a mismatch.
      tbl[0]  = mk(1, 0, 1, 1, 0, 0, 0, 0);
      tbl[1]  = mk(1, 0, 1, 1, 0, 0, 0, 0);
      tbl[2]  = mk(1, 0, 1, 1, 1, 0, 0, 1);
      tbl[3]  = mk(1, 0, 1, 1, 1, 0, 0, 1);
      tbl[4]  = mk(1, 0, 1, 1, 3, 1, 1, 1);
      tbl[5]  = mk(1, 0, 0, 0, 3, 0, 1, 1);
      tbl[6]  = mk(1, 0, 0, 0, 3, 0, 1, 1);
      tbl[7]  = mk(1, 0, 0, 0, 3, 0, 1, 2);
      tbl[8]  = mk(1, 1, 0, 0, 0, 0, 0, 0);
      tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
      tbl[10] = mk(1, 0, 1, 1, 0, 0, 0, 0);
      tbl[11] = mk(1, 0, 1, 1, 0, 0, 0, 0);
      tbl[12] = mk(1, 0, 1, 1, 1, 0, 0, 1);
      tbl[13] = mk(1, 0, 1, 1, 1, 0, 0, 1);
      tbl[14] = mk(1, 1, 1, 1, 0, 0, 0, 0);
      tbl[15] = mk(1, 0, 1, 1, 0, 0, 0, 0);

      rst_n = 1'b1; en = 1'b0; clr = 1'b0; stim = 1'b0; resp = 1'b0;
      model_reset();
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven vectors.
      for (int i = 0; i < 16; i++) begin
         en = tbl[i].en; clr = tbl[i].clr; stim = tbl[i].s; resp = tbl[i].r;
         step();
         chk($sformatf("tbl%0d_state", i), 32'(state), tbl[i].st);
         chk($sformatf("tbl%0d_err", i), 32'(err_pulse), int'(tbl[i].err));
         chk($sformatf("tbl%0d_mis", i), 32'(mismatch), int'(tbl[i].mis));
         chk($sformatf("tbl%0d_edges", i), 32'(edge_cnt), tbl[i].edges);
      end

      // Ideal inverter toggling every 10 cycles for 100 cycles.
      clr = 1'b1; step(); clr = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (i % 10 == 0) stim = ~stim;
         resp = ~stim;
         step();
      end
      repeat (5) step();
      chk("ideal_mismatch", 32'(mismatch), 0);
      chk("ideal_edges", 32'(edge_cnt), 10);
`ifdef SWITCH_CHK_PERIOD_EN
      chk("ideal_half_per", 32'(half_per), 10);
`else
      chk("ideal_half_per", 32'(half_per), 0);
`endif

      // Response lagging by one cycle: inside the settle window.
      clr = 1'b1; step(); clr = 1'b0;
      for (int i = 0; i < 60; i++) begin
         resp = ~stim;
         if (i % 7 == 0) stim = ~stim;
         step();
      end
      chk("lag1_mismatch", 32'(mismatch), 0);

      // Response lagging by three cycles: outlasts the settle window.
      clr = 1'b1; step(); clr = 1'b0;
      for (int k = 0; k < 4; k++) dly[k] = int'(~stim);
      for (int i = 0; i < 40; i++) begin
         if (i % 8 == 0) stim = ~stim;
         dly[3] = dly[2]; dly[2] = dly[1]; dly[1] = dly[0]; dly[0] = int'(~stim);
         resp = dly[3][0];
         step();
      end
      chk("lag3_mismatch", 32'(mismatch), 1);

      // Enable dropped while checking: back to IDLE, edge count holds.
      clr = 1'b1; step(); clr = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (i % 6 == 0) stim = ~stim;
         resp = ~stim;
         step();
      end
      saved_edges = m_edges;
      en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i % 4 == 0) stim = ~stim;
         resp = ~stim;
         step();
      end
      chk("endrop_state", 32'(state), 0);
      chk("endrop_edges", 32'(edge_cnt), saved_edges);
      en = 1'b1;

      // Stimulus held constant long enough to trip stuck detection.
      clr = 1'b1; step(); clr = 1'b0;
      resp = ~stim;
      repeat (1030) step();
`ifdef SWITCH_CHK_PERIOD_EN
      chk("stuck_set", 32'(stuck), 1);
`else
      chk("stuck_off", 32'(stuck), 0);
      chk("stuck_off_half", 32'(half_per), 0);
`endif

      // Reset pulsed in CHECK with stim high; one edge after release.
      clr = 1'b1; step(); clr = 1'b0;
      stim = 1'b0; resp = 1'b1;
      repeat (4) step();
      stim = 1'b1; resp = 1'b0;
      repeat (7) step();
      chk("prerst_state", 32'(state), 2);
      rst_n = 1'b0;
      #2;
      model_reset();
      check_all_zero("midrst");
      #2 rst_n = 1'b1;
      repeat (3) step();
      chk("postrst_edges", 32'(edge_cnt), 1);

      // Randomized traffic against the model.
      hp = 3;
      for (int i = 0; i < 2500; i++) begin
         if (hp == 0) begin
            stim = ~stim;
            hp = int'($urandom_range(1, 14));
         end else begin
            hp--;
         end
         resp = ($urandom_range(0, 59) == 0) ? stim : ~stim;
         clr  = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 99) == 0) en = ~en;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
